// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a debounced
// lock with bounded retries, and releases downstream reset only while lock holds.
module pll_lock_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16,
  parameter int RETRY_W             = 4
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         lock_loss_cnt
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL_ST   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   timer, timer_nx;
  logic [RETRY_W-1:0] retry_nx;
  logic [7:0]         loss_nx;
  logic               locked_p0, locked_s;

  // Stage p0/s: two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      locked_p0 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      locked_p0 <= pll_locked;
      locked_s  <= locked_p0;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer + CNT_W'(1);
    retry_nx = retry_cnt;
    loss_nx  = lock_loss_cnt;
    if (restart) begin
      state_nx = RESET_PLL;
      timer_nx = '0;
      retry_nx = '0;
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            state_nx = WAIT_LOCK;
            timer_nx = '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nx = STABLE;
            timer_nx = '0;
          end else if (timer == TIMEOUT_LST) begin
            timer_nx = '0;
            if (retry_cnt == RETRY_MAX) begin
              state_nx = FAIL_ST;
            end else begin
              state_nx = RESET_PLL;
              retry_nx = retry_cnt + RETRY_W'(1);
            end
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nx = WAIT_LOCK;
            timer_nx = '0;
          end else if (timer == STABLE_LST) begin
            state_nx = RUN;
            timer_nx = '0;
          end
        end
        RUN: begin
          timer_nx = timer;
          if (!locked_s) begin
            state_nx = RESET_PLL;
            timer_nx = '0;
            retry_nx = '0;
            if (lock_loss_cnt != 8'hFF) loss_nx = lock_loss_cnt + 8'd1;
          end
        end
        FAIL_ST: begin
          timer_nx = timer;
        end
        default: begin
          state_nx = RESET_PLL;
          timer_nx = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state         <= RESET_PLL;
      timer         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      retry_cnt     <= retry_nx;
      lock_loss_cnt <= loss_nx;
      pll_rst       <= (state_nx == RESET_PLL) || (state_nx == FAIL_ST);
      sys_rst_n     <= (state_nx == RUN);
      ready         <= (state_nx == RUN);
      fail          <= (state_nx == FAIL_ST);
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small timing parameters and hand-derived edge counts.
module tb_pll_lock_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_chk = 0;
  int n_pass = 0;

  pll_lock_ctrl #(
    .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2), .CNT_W(16), .RETRY_W(4)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset(input string tag, input logic lock_in);
    rst_n = 1'b0;
    restart = 1'b0;
    pll_locked = lock_in;
    repeat (3) tick();
    check({tag, "_pll_rst"}, pll_rst, 1);
    check({tag, "_sys_rst_n"}, sys_rst_n, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_retry"}, retry_cnt, 0);
    check({tag, "_loss"}, lock_loss_cnt, 0);
    rst_n = 1'b1;
  endtask

  // Ticks until ready equals want; returns edges taken, reports a FAIL on timeout
  task automatic wait_ready(input string tag, input logic want, input int bound, output int n);
    n = 0;
    while (ready !== want && n < bound) begin
      tick();
      n++;
    end
    if (ready !== want) check({tag, "_timeout"}, ready, want);
  endtask

  // Ticks until pll_rst drops; returns number of edges it stayed high
  task automatic rst_width(output int n);
    n = 0;
    while (pll_rst && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int fall_at[4];
    int n_fall, fail_at, first_ready, rst_seen;
    logic prev;

    // 1: normal bring-up, lock raised 6 edges after pll_rst falls
    do_reset("t1_reset", 1'b0);
    rst_width(n);
    check("t1_rst_width", n, 4);
    repeat (5) tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    check("t1_ready_early", ready, 0);
    tick();
    check("t1_ready", ready, 1);
    check("t1_sys_rst_n", sys_rst_n, 1);
    check("t1_retry", retry_cnt, 0);
    check("t1_fail", fail, 0);
    check("t1_pll_rst", pll_rst, 0);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    tick();
    tick();
    check("t4_ready_hold", ready, 1);
    tick();
    check("t4_sys_rst_n", sys_rst_n, 0);
    check("t4_ready", ready, 0);
    check("t4_pll_rst", pll_rst, 1);
    check("t4_loss", lock_loss_cnt, 1);
    check("t4_retry", retry_cnt, 0);
    pll_locked = 1'b1;
    wait_ready("t4_reacq", 1'b1, 100, n);
    check("t4_reacq_edges", n, 13);
    check("t4_loss_kept", lock_loss_cnt, 1);

    // 3: one-cycle glitch seen by the FSM at STABLE count 5
    do_reset("t3_reset", 1'b1);
    first_ready = 0;
    rst_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 8) pll_locked = 1'b0;
      if (i == 9) pll_locked = 1'b1;
      if (ready && first_ready == 0) first_ready = i;
      if (i > 4 && pll_rst) rst_seen = 1;
    end
    check("t3_ready_edge", first_ready, 20);
    check("t3_no_rst_pulse", rst_seen, 0);

    // 2: timeout to fail with lock never asserted
    do_reset("t2_reset", 1'b0);
    n_fall = 0;
    fail_at = 0;
    prev = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (prev && !pll_rst) begin
        if (n_fall < 4) fall_at[n_fall] = i;
        n_fall++;
      end
      if (fail && fail_at == 0) fail_at = i;
      if (i == 30) check("t2_retry_mid", retry_cnt, 1);
      prev = pll_rst;
    end
    check("t2_n_pulses", n_fall, 3);
    check("t2_fall0", fall_at[0], 4);
    check("t2_fall1", fall_at[1], 28);
    check("t2_fall2", fall_at[2], 52);
    check("t2_fail_edge", fail_at, 72);
    check("t2_fail", fail, 1);
    check("t2_pll_rst", pll_rst, 1);
    check("t2_retry", retry_cnt, 2);
    check("t2_sys_rst_n", sys_rst_n, 0);

    // 5a: restart from FAIL
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("t5_fail_clr", fail, 0);
    check("t5_retry_clr", retry_cnt, 0);
    check("t5_pll_rst", pll_rst, 1);
    rst_width(n);
    check("t5_rst_width", n, 4);

    // 5b: restart coincident with the FSM seeing a lock drop in RUN
    pll_locked = 1'b1;
    wait_ready("t5_run", 1'b1, 100, n);
    pll_locked = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    check("t5_run_loss", lock_loss_cnt, 0);
    check("t5_run_ready", ready, 0);
    check("t5_run_pll_rst", pll_rst, 1);
    repeat (10) tick();
    check("t5_hold_pll_rst", pll_rst, 1);
    restart = 1'b0;
    rst_width(n);
    check("t5_hold_width", n, 4);

    // 6: lock-loss saturation, then rst_n while in WAIT_LOCK
    do_reset("t6_reset", 1'b1);
    wait_ready("t6_run", 1'b1, 100, n);
    for (int k = 1; k <= 260; k++) begin
      pll_locked = 1'b0;
      wait_ready("t6_drop", 1'b0, 10, n);
      if (k == 1) check("t6_loss_1", lock_loss_cnt, 1);
      if (k == 255) check("t6_loss_255", lock_loss_cnt, 255);
      pll_locked = 1'b1;
      wait_ready("t6_reacq", 1'b1, 100, n);
    end
    check("t6_loss_sat", lock_loss_cnt, 255);
    pll_locked = 1'b0;
    wait_ready("t6_last_drop", 1'b0, 10, n);
    rst_width(n);
    repeat (3) tick();
    check("t6_wait_pll_rst", pll_rst, 0);
    check("t6_loss_still", lock_loss_cnt, 255);
    rst_n = 1'b0;
    tick();
    check("t6_mid_pll_rst", pll_rst, 1);
    check("t6_mid_sys_rst_n", sys_rst_n, 0);
    check("t6_mid_ready", ready, 0);
    check("t6_mid_fail", fail, 0);
    check("t6_mid_retry", retry_cnt, 0);
    check("t6_mid_loss", lock_loss_cnt, 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
